vedic_mac_accum: RTL and testbench
==================================

Name: vedic_mac_accum

Overview:
Downstream stage of the 8x8 Vedic multiplier. It consumes the 16-bit product stream through a valid/ready handshake and accumulates successive products into a wider register. When a group closes, it presents the dot-product result, term count and overflow flag on a held output handshake. This turns the combinational multiplier into a sequential multiply-accumulate path for the tile.

Parameters:
PROD_W, 16, width of incoming product (matches 8x8 multiplier output)
ACC_W, 24, accumulator width; must be >= PROD_W+1
CNT_W, 4, term-counter width; MAX_TERMS = 2^CNT_W - 1 (15 by default)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous abort: discard group, return to IDLE
in_valid  input  1  product beat valid
in_ready  output  1  stage can accept a beat
in_prod  input  PROD_W  unsigned product from multiplier
in_last  input  1  beat closes current group
out_valid  output  1  accumulated result available
out_ready  input  1  consumer accepts result
out_acc  output  ACC_W  accumulated sum (mod 2^ACC_W)
out_count  output  CNT_W  number of terms in group (1..MAX_TERMS)
out_ovf  output  1  sticky: a carry out of ACC_W occurred in this group

Behaviour:
- Reset (async, rst=1): state=IDLE; acc, count, ovf = 0; out_valid=0; in_ready goes to 1 on the first edge after release. All outputs are 0 during reset.
- States:
  - IDLE: no terms held.
  - ACCUM: 1 or more terms held, group open.
  - HOLD: result presented.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. in_ready is a function of state only, never of in_valid.
- Beat accepted when in_valid && in_ready:
  - acc <= acc + zero-extend(in_prod), truncated to ACC_W.
  - ovf <= ovf | carry-out.
  - count <= count + 1.
- Group close: the accepted beat has in_last=1, OR the increment makes count == MAX_TERMS. Close goes to HOLD; otherwise go to ACCUM.
- Latency: out_valid rises on the edge after the closing beat is accepted (1 cycle). out_acc already includes that beat.
- HOLD:
  - out_valid=1; out_acc, out_count, out_ovf equal acc, count, ovf.
  - Outputs stay stable until out_ready=1.
  - On out_valid && out_ready: go to IDLE, acc/count/ovf <= 0, out_valid <= 0 on that edge.
- No bypass: a beat cannot be accepted in the same cycle the result is released. The first beat of the next group is accepted at the earliest one cycle after the release.
- out_valid is 0 outside HOLD; out_acc, out_count, out_ovf read 0 outside HOLD.
- clear=1 (synchronous) in any state: next state IDLE, acc/count/ovf <= 0, out_valid <= 0.
  - clear has priority over a concurrent beat; that beat is dropped even though in_ready=1.
  - clear has priority over a concurrent out handshake.
- in_last with in_valid=0 is ignored.
- rst asserted mid-group or mid-HOLD: immediate return to reset values; the group is lost.
- Arithmetic is unsigned only. Wrap-around modulo 2^ACC_W, flagged by out_ovf.

Decomposition:
- Shared package vedic_pkg:
  - PROD_W default constant
  - state typedef (IDLE, ACCUM, HOLD)
  - function computing MAX_TERMS from CNT_W
- One sub-module, vedic_acc_dp: ACC_W adder, accumulator register, sticky carry-out flag, term counter, with load/clear/enable controls.
- The FSM and handshake logic stay in vedic_mac_accum.

Test Plan:
- Reset, then 3 beats of 65025 (255*255) with in_last on the 3rd, out_ready=1 -> out_valid exactly 1 cycle after 3rd beat; out_acc=195075 (0x2FA03), out_count=3, out_ovf=0.
- ACC_W=17 override; 3 beats of 65025, last on the 3rd -> out_acc=64003, out_ovf=1, out_count=3.
- 15 beats of value 1, in_last never asserted -> auto-close after 15th beat; out_acc=15, out_count=15; in_ready=0 in the following cycle.
- Result in HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs unchanged, no beat accepted. Raise out_ready -> IDLE next edge, out_valid=0, next beat accepted 1 cycle later.
- 2 beats (100, 200), then clear=1 coinciding with a third beat (300), then 1 beat 7 with in_last -> out_acc=7, out_count=1 (the 300 beat is dropped).
- Async rst pulse mid-cycle while in HOLD with out_acc=195075 -> out_valid and out_acc go to 0 without waiting for a clock edge. Recovery group: 1 beat 42 with last -> out_acc=42.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared types and constants for the Vedic multiply-accumulate path.
package vedic_pkg;

  // Width of the 8x8 multiplier product.
  localparam int unsigned PROD_W_DEF = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  // Largest term count a CNT_W-bit counter can report.
  function automatic int unsigned max_terms(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/vedic_acc_dp.sv
// Accumulator datapath: adder, sum register, sticky carry flag and term counter.
module vedic_acc_dp #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  // One extra bit captures the carry out of the accumulator.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};

  // Next-state: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      acc_d = sum[ACC_W-1:0];
      cnt_d = cnt_q + 1'b1;
      ovf_d = ovf_q | sum[ACC_W];
    end
  end

  // Datapath state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/vedic_mac_accum.sv
// Multiply-accumulate stage: sums product beats into groups and presents
// each closed group on a held valid/ready output.
module vedic_mac_accum
  import vedic_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam int unsigned    MaxTerms = max_terms(CNT_W);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MaxTerms - 1);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept;
  logic             close;
  logic             release_res;
  logic             dp_clr;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  // Handshake decode; clear drops any concurrent beat or release.
  always_comb begin
    accept      = in_valid && in_ready_q && !clear;
    close       = accept && (in_last || (cnt == LastCnt));
    release_res = out_valid_q && out_ready && !clear;
    dp_clr      = clear || release_res;
  end

  vedic_acc_dp #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk   (clk),
    .rst   (rst),
    .clr_i (dp_clr),
    .en_i  (accept),
    .prod_i(in_prod),
    .acc_o (acc),
    .cnt_o (cnt),
    .ovf_o (ovf)
  );

  // Group FSM with registered handshake outputs; in_ready depends on state only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          in_ready_q <= 1'b1;
          if (close) begin
            state_q     <= StHold;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (accept) begin
            state_q <= StAccum;
          end
        end
        StHold: begin
          if (release_res) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // Result fields read zero unless a result is being presented.
  assign out_acc   = out_valid_q ? acc : '0;
  assign out_count = out_valid_q ? cnt : '0;
  assign out_ovf   = out_valid_q & ovf;

endmodule

// File: tb/tb_vedic_mac_accum.sv
// Scoreboard bench for vedic_mac_accum: a default instance and an ACC_W=17
// instance share stimulus; a monitor checks each released result.
module tb_vedic_mac_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [23:0] a_out_acc;
  logic [3:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [16:0] b_out_acc;
  logic [3:0]  b_out_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] acc;
    logic [3:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  vedic_mac_accum dut_a (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (a_in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(a_out_valid),
    .out_ready(out_ready),
    .out_acc  (a_out_acc),
    .out_count(a_out_count),
    .out_ovf  (a_out_ovf)
  );

  vedic_mac_accum #(.ACC_W(17)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (b_in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(b_out_valid),
    .out_ready(out_ready),
    .out_acc  (b_out_acc),
    .out_count(b_out_count),
    .out_ovf  (b_out_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [23:0] acc_a, input logic [16:0] acc_b,
                            input logic [3:0] cnt, input logic ovf_a, input logic ovf_b);
    exp_t e;
    e.acc = acc_a; e.cnt = cnt; e.ovf = ovf_a;
    q_a.push_back(e);
    e.acc = {7'd0, acc_b}; e.ovf = ovf_b;
    q_b.push_back(e);
  endtask

  // Present one beat and hold it until the edge that accepts it.
  task automatic send_beat(input logic [15:0] p, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("beat_ready_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((a_out_valid || !a_in_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  // Monitor: every released result is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_ready && a_out_valid) begin
      if (q_a.size() == 0) chk("a_unexpected_result", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_out_acc", 32'(a_out_acc), 32'(e.acc));
        chk("a_out_count", 32'(a_out_count), 32'(e.cnt));
        chk("a_out_ovf", 32'(a_out_ovf), 32'(e.ovf));
      end
    end
    if (!rst && out_ready && b_out_valid) begin
      if (q_b.size() == 0) chk("b_unexpected_result", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_out_acc", 32'(b_out_acc), 32'(e.acc));
        chk("b_out_count", 32'(b_out_count), 32'(e.cnt));
        chk("b_out_ovf", 32'(b_out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_out_acc", 32'(a_out_acc), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(a_in_ready), 32'd1);

    // 3 x 65025: 195075 in 24 bits; 64003 with carry in 17 bits
    out_ready = 1'b1;
    expect_res(24'd195075, 17'd64003, 4'd3, 1'b0, 1'b1);
    send_beat(16'd65025, 1'b0);
    send_beat(16'd65025, 1'b0);
    chk("no_valid_before_close", 32'(a_out_valid), 32'd0);
    send_beat(16'd65025, 1'b1);
    chk("valid_one_cycle_after_close", 32'(a_out_valid), 32'd1);
    wait_idle();

    // 15 beats of 1 with no last: closes on the counter limit
    expect_res(24'd15, 17'd15, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) send_beat(16'd1, 1'b0);
    chk("autoclose_in_ready", 32'(a_in_ready), 32'd0);
    chk("autoclose_valid", 32'(a_out_valid), 32'd1);
    wait_idle();

    // Hold with out_ready low while beats are offered
    out_ready = 1'b0;
    expect_res(24'd1234, 17'd1234, 4'd1, 1'b0, 1'b0);
    expect_res(24'd999, 17'd999, 4'd1, 1'b0, 1'b0);
    send_beat(16'd1234, 1'b1);
    in_valid = 1'b1;
    in_prod  = 16'd999;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_in_ready", 32'(a_in_ready), 32'd0);
      chk("hold_out_acc", 32'(a_out_acc), 32'd1234);
      chk("hold_out_count", 32'(a_out_count), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 32'(a_out_valid), 32'd0);
    chk("release_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("next_beat_after_release", 32'(a_out_acc), 32'd999);
    wait_idle();

    // clear drops the concurrent 300 beat and the partial group
    send_beat(16'd100, 1'b0);
    send_beat(16'd200, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 16'd300;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_out_valid", 32'(a_out_valid), 32'd0);
    chk("clear_in_ready", 32'(a_in_ready), 32'd1);
    expect_res(24'd7, 17'd7, 4'd1, 1'b0, 1'b0);
    send_beat(16'd7, 1'b1);
    wait_idle();

    // Async reset while holding a result
    out_ready = 1'b0;
    send_beat(16'd65025, 1'b0);
    send_beat(16'd65025, 1'b0);
    send_beat(16'd65025, 1'b1);
    chk("pre_rst_acc", 32'(a_out_acc), 32'd195075);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(a_out_valid), 32'd0);
    chk("async_rst_acc", 32'(a_out_acc), 32'd0);
    chk("async_rst_b_acc", 32'(b_out_acc), 32'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    expect_res(24'd42, 17'd42, 4'd1, 1'b0, 1'b0);
    send_beat(16'd42, 1'b1);
    wait_idle();
    repeat (2) @(posedge clk);

    chk("a_results_pending", 32'(q_a.size()), 32'd0);
    chk("b_results_pending", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
